// File: rtl/sha1_timer_pkg.sv
// Shared definitions for the SHA1 multi-channel interval timer:
// register offsets, control/status bit positions and the global page location.
package sha1_timer_pkg;

  localparam int REGS_PER_CH = 4;

  localparam logic [1:0] REG_STATUS  = 2'd0;
  localparam logic [1:0] REG_CONTROL = 2'd1;
  localparam logic [1:0] REG_PERIOD  = 2'd2;
  localparam logic [1:0] REG_SNAP    = 2'd3;

  localparam int CTL_ITO   = 0;
  localparam int CTL_CONT  = 1;
  localparam int CTL_START = 2;
  localparam int CTL_STOP  = 3;

  localparam int ST_TO  = 0;
  localparam int ST_RUN = 1;

  // Per-channel register write strobes decoded at the top level.
  typedef struct packed {
    logic status;
    logic control;
    logic period;
    logic snap;
  } ch_wr_t;

  // The global page sits directly above the last channel's register block.
  function automatic int global_page(input int num_ch);
    return num_ch * REGS_PER_CH;
  endfunction

endpackage

// File: rtl/sha1_multi_timer_if.sv
// Avalon-MM slave signal bundle for the multi-channel timer.
interface sha1_multi_timer_if #(
  parameter int ADDR_W = 5
);
  logic              chipselect;
  logic [ADDR_W-1:0] address;
  logic              write_n;
  logic [31:0]       writedata;
  logic [31:0]       readdata;

  modport master (output chipselect, address, write_n, writedata, input readdata);
  modport slave  (input chipselect, address, write_n, writedata, output readdata);
endinterface

// File: rtl/sha1_timer_channel.sv
// One timer channel: down-counter, period, snapshot, control bits, RUN/TO,
// zero-edge timeout detection and the registered timeout pulse.
module sha1_timer_channel
  import sha1_timer_pkg::*;
#(
  parameter int          COUNT_W   = 32,
  parameter int unsigned RESET_PER = 49999
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               tick,
  input  ch_wr_t             wr,
  input  logic [COUNT_W-1:0] wdata,
  input  logic [1:0]         rsel,
  output logic [31:0]        rdata,
  output logic               to_irq,
  output logic               pulse
);

  localparam logic [COUNT_W-1:0] RST_VAL = COUNT_W'(RESET_PER);

  logic [COUNT_W-1:0] cnt, period, snap;
  logic cont, ito, run, to, zero_prev, reload_pend;
  logic cnt_zero, timeout_event, start, stop;

  assign cnt_zero      = (cnt == '0);
  assign timeout_event = cnt_zero & ~zero_prev;
  assign start         = wr.control & wdata[CTL_START];
  assign stop          = wr.control & wdata[CTL_STOP];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt         <= RST_VAL;
      period      <= RST_VAL;
      snap        <= '0;
      cont        <= 1'b0;
      ito         <= 1'b0;
      run         <= 1'b0;
      to          <= 1'b0;
      zero_prev   <= (RST_VAL == '0);  // no spurious event when leaving reset
      reload_pend <= 1'b0;
      pulse       <= 1'b0;
    end else begin
      zero_prev   <= cnt_zero;
      pulse       <= timeout_event;
      reload_pend <= wr.period;
      if (wr.period) period <= wdata;
      if (wr.control) begin
        cont <= wdata[CTL_CONT];
        ito  <= wdata[CTL_ITO];
      end
      if (wr.snap) snap <= cnt;
      // A timeout in the same cycle as a clear keeps TO set.
      if (timeout_event)  to <= 1'b1;
      else if (wr.status) to <= 1'b0;

      if (reload_pend)      cnt <= period;
      else if (run && tick) cnt <= cnt_zero ? (cont ? period : cnt) : cnt - 1'b1;

      if (start)                                     run <= 1'b1;
      else if (stop || wr.period || reload_pend)     run <= 1'b0;
      else if (run && tick && cnt_zero && !cont)     run <= 1'b0;
    end
  end

  always_comb begin
    rdata = '0;
    case (rsel)
      REG_STATUS: begin
        rdata[ST_TO]  = to;
        rdata[ST_RUN] = run;
      end
      REG_CONTROL: begin
        rdata[CTL_ITO]  = ito;
        rdata[CTL_CONT] = cont;
      end
      REG_PERIOD: rdata[COUNT_W-1:0] = period;
      REG_SNAP:   rdata[COUNT_W-1:0] = snap;
      default:    rdata = '0;
    endcase
  end

  assign to_irq = to & ito;

endmodule

// File: rtl/sha1_multi_timer.sv
// N-channel interval timer on an Avalon-MM slave with a combined irq.
// Optional shared prescaler enabled by defining SHA1_TIMER_PRESCALE_EN.
module sha1_multi_timer
  import sha1_timer_pkg::*;
#(
  parameter int          NUM_CH    = 4,
  parameter int          COUNT_W   = 32,
  parameter int unsigned RESET_PER = 49999
) (
  input  logic                clk,
  input  logic                reset_n,
  sha1_multi_timer_if.slave   bus,
  output logic                irq,
  output logic [NUM_CH-1:0]   timeout_pulse
);

  localparam int ADDR_W   = $clog2(NUM_CH) + 3;
  localparam int CH_SEL_W = ADDR_W - 2;
  localparam int GP_ADDR  = global_page(NUM_CH);

  logic                wr_en, rd_en, in_range, is_global, tick;
  logic [CH_SEL_W-1:0] ch_sel;
  logic [1:0]          reg_sel;
  logic [31:0]         ch_rdata [NUM_CH];
  logic [NUM_CH-1:0]   ch_irq;
  logic [31:0]         global_rd, rd_mux, readdata;

  assign wr_en     = bus.chipselect & ~bus.write_n;
  assign rd_en     = bus.chipselect &  bus.write_n;
  assign ch_sel    = bus.address[ADDR_W-1:2];
  assign reg_sel   = bus.address[1:0];
  assign in_range  = (bus.address < ADDR_W'(GP_ADDR));
  assign is_global = (bus.address == ADDR_W'(GP_ADDR));

`ifdef SHA1_TIMER_PRESCALE_EN
  logic [15:0] prescale, div;

  assign tick      = (div == prescale);
  assign global_rd = {16'b0, prescale};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prescale <= '0;
      div      <= '0;
    end else if (wr_en && is_global) begin
      prescale <= bus.writedata[15:0];
      div      <= '0;
    end else if (tick) begin
      div <= '0;
    end else begin
      div <= div + 16'd1;
    end
  end
`else
  assign tick      = 1'b1;
  assign global_rd = '0;
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    ch_wr_t wr;

    always_comb begin
      wr = '0;
      if (wr_en && in_range && ch_sel == CH_SEL_W'(i)) begin
        case (reg_sel)
          REG_STATUS:  wr.status  = 1'b1;
          REG_CONTROL: wr.control = 1'b1;
          REG_PERIOD:  wr.period  = 1'b1;
          REG_SNAP:    wr.snap    = 1'b1;
          default:     wr = '0;
        endcase
      end
    end

    sha1_timer_channel #(
      .COUNT_W  (COUNT_W),
      .RESET_PER(RESET_PER)
    ) u_ch (
      .clk    (clk),
      .reset_n(reset_n),
      .tick   (tick),
      .wr     (wr),
      .wdata  (bus.writedata[COUNT_W-1:0]),
      .rsel   (reg_sel),
      .rdata  (ch_rdata[i]),
      .to_irq (ch_irq[i]),
      .pulse  (timeout_pulse[i])
    );
  end

  always_comb begin
    rd_mux = '0;
    if (is_global) rd_mux = global_rd;
    for (int i = 0; i < NUM_CH; i++) begin
      if (in_range && ch_sel == CH_SEL_W'(i)) rd_mux = ch_rdata[i];
    end
  end

  // Registered read path gives the one-cycle read latency.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   readdata <= '0;
    else if (rd_en) readdata <= rd_mux;
  end

  assign bus.readdata = readdata;
  assign irq          = |ch_irq;

endmodule

// File: tb/tb_sha1_multi_timer.sv
// Directed self-checking bench for sha1_multi_timer; read results flow
// through an expected-value queue and are checked with immediate assertions.
module tb_sha1_multi_timer;
  import sha1_timer_pkg::*;

  localparam int NUM_CH = 4;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              irq;
  logic [NUM_CH-1:0] timeout_pulse;

  int errors = 0;
  int checks = 0;

  sha1_multi_timer_if #(.ADDR_W(ADDR_W)) bus ();

  sha1_multi_timer #(
    .NUM_CH   (NUM_CH),
    .COUNT_W  (32),
    .RESET_PER(49999)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .bus          (bus),
    .irq          (irq),
    .timeout_pulse(timeout_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] expv;
  } sb_t;

  sb_t sb_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic write_reg(input int addr, input logic [31:0] data);
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.address    = ADDR_W'(addr);
    bus.writedata  = data;
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic read_reg(input int addr, input logic [31:0] expv, input string tag);
    sb_t e;
    e.tag  = tag;
    e.expv = expv;
    sb_q.push_back(e);
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b1;
    bus.address    = ADDR_W'(addr);
    @(negedge clk);
    bus.chipselect = 1'b0;
    e = sb_q.pop_front();
    check(e.tag, bus.readdata, e.expv);
  endtask

  // Steps negedges until the channel pulse is seen or the budget runs out.
  task automatic wait_pulse(input int ch, input int max_cyc, output int cyc, output logic irq_before);
    cyc        = 0;
    irq_before = irq;
    do begin
      irq_before = irq;
      @(negedge clk);
      cyc++;
    end while (!timeout_pulse[ch] && cyc < max_cyc);
    check($sformatf("pulse_seen_ch%0d", ch), 32'(timeout_pulse[ch]), 32'd1);
  endtask

  initial begin
    int   c;
    int   n;
    int   exp_int;
    logic [31:0] exp_gp;
    logic ib;

    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.address    = '0;
    bus.writedata  = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Reset state
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_pulse", 32'(timeout_pulse), 32'd0);
    check("rst_readdata", bus.readdata, 32'd0);
    read_reg(2, 32'd49999, "ch0_period_rst");
    read_reg(0, 32'd0, "ch0_status_rst");
    read_reg(3, 32'd0, "ch0_snap_rst");
    read_reg(1, 32'd0, "ch0_control_rst");

    // Continuous channel 1, period 5
    write_reg(6, 32'd5);
    write_reg(5, 32'h7);
    wait_pulse(1, 20, c, ib);
    check("ch1_irq_before_event", 32'(ib), 32'd0);
    check("ch1_irq_after_event", 32'(irq), 32'd1);
    wait_pulse(1, 20, c, ib);
    check("ch1_interval", 32'(c), 32'd6);
    write_reg(4, 32'd1);
    check("ch1_irq_cleared", 32'(irq), 32'd0);
    read_reg(4, 32'h2, "ch1_status_run");

    // One-shot channel 2, period 3
    write_reg(10, 32'd3);
    write_reg(9, 32'h4);
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (timeout_pulse[2]) n++;
    end
    check("ch2_oneshot_pulses", 32'(n), 32'd1);
    read_reg(8, 32'h1, "ch2_status_oneshot");
    write_reg(11, 32'd0);
    read_reg(11, 32'd0, "ch2_snap_zero");

    // STATUS clear coinciding with a channel 1 timeout event
    wait_pulse(1, 20, c, ib);
    write_reg(4, 32'd1);
    check("ch1_irq_clear2", 32'(irq), 32'd0);
    repeat (4) @(negedge clk);
    write_reg(4, 32'd1);
    check("ch1_pulse_aligned", 32'(timeout_pulse[1]), 32'd1);
    check("ch1_to_kept_irq", 32'(irq), 32'd1);
    read_reg(4, 32'h3, "ch1_status_to_kept");

    // START and STOP in the same write
    write_reg(9, 32'hE);
    read_reg(8, 32'h3, "ch2_start_wins");

    // Channel 0 snapshot and PERIOD write while counting
    write_reg(1, 32'h6);
    write_reg(3, 32'd0);
    read_reg(3, 32'd49999, "ch0_snap_predec");
    repeat (3) @(negedge clk);
    write_reg(2, 32'd10);
    read_reg(0, 32'd0, "ch0_status_after_period");
    write_reg(3, 32'd0);
    read_reg(3, 32'd10, "ch0_snap_reload");

    // Channel 3 rate, with or without the prescaler
`ifdef SHA1_TIMER_PRESCALE_EN
    write_reg(16, 32'd3);
    exp_int = 12;
    exp_gp  = 32'd3;
`else
    exp_int = 3;
    exp_gp  = 32'd0;
`endif
    write_reg(14, 32'd2);
    write_reg(13, 32'h6);
    wait_pulse(3, 40, c, ib);
    wait_pulse(3, 40, c, ib);
    check("ch3_interval", 32'(c), 32'(exp_int));
    read_reg(16, exp_gp, "global_page");
    read_reg(31, 32'd0, "unmapped_read");

    // Asynchronous reset mid-count
    read_reg(14, 32'd2, "ch3_period_pre_rst");
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_pulse", 32'(timeout_pulse), 32'd0);
    check("async_rst_irq", 32'(irq), 32'd0);
    check("async_rst_readdata", bus.readdata, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    read_reg(14, 32'd49999, "ch3_period_after_rst");
    read_reg(4, 32'd0, "ch1_status_after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
